// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles SOF/CMD/ARG/CHK frames from the uart_rx byte
// stream, validates them, emits one-cycle cmd_valid / frame_error strobes
// and keeps the out_enable state.
// Optional feature macro: CMD_ECHO_EN (adds an ACK/NAK byte path for uart_tx).
module uart_cmd_parser #(
  parameter logic [7:0] SOF_BYTE       = 8'h7E,
  parameter int         TIMEOUT_CYCLES = 6000,
  parameter logic [7:0] CODE_ON        = 8'hAA,
  parameter logic [7:0] CODE_OFF       = 8'h55,
  parameter logic [7:0] CODE_TOGGLE    = 8'hC3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       rx_parity_error,
`ifdef CMD_ECHO_EN
  input  logic       tx_busy,
  output logic [7:0] ack_data,
  output logic       ack_start,
`endif
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic [7:0] cmd_arg,
  output logic       frame_error,
  output logic [7:0] err_count,
  output logic       out_enable
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    NAK_BYTE = 8'h15;

  typedef enum logic [1:0] {IDLE, GET_CMD, GET_ARG, GET_CHK} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          rx_done_q;
  logic [7:0]    cmd_r_q, cmd_r_d, arg_r_q, arg_r_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          frame_error_q, frame_error_d;
  logic [7:0]    cmd_code_q, cmd_code_d, cmd_arg_q, cmd_arg_d;
  logic [7:0]    err_count_q, err_count_d;
  logic          out_enable_q, out_enable_d;
  logic          strb, good, bad;

  // Rising edge of rx_done marks a new byte; works for pulse or level inputs.
  always_comb begin
    strb = rx_done & ~rx_done_q;
    good = strb & ~rx_parity_error;
    bad  = strb & rx_parity_error;
  end

  // Frame FSM next-state, timeout and output strobe computation.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    cmd_r_d       = cmd_r_q;
    arg_r_d       = arg_r_q;
    cmd_valid_d   = 1'b0;
    frame_error_d = 1'b0;
    cmd_code_d    = cmd_code_q;
    cmd_arg_d     = cmd_arg_q;
    out_enable_d  = out_enable_q;
    err_count_d   = err_count_q;

    if (state_q == IDLE) begin
      // Anything but a clean SOF is dropped silently while hunting.
      timer_d = '0;
      if (good && rx_data == SOF_BYTE) state_d = GET_CMD;
    end else if (strb) begin
      // A byte arriving on the timeout cycle still counts.
      timer_d = '0;
      if (bad) begin
        frame_error_d = 1'b1;
        state_d       = IDLE;
      end else begin
        case (state_q)
          GET_CMD: begin
            cmd_r_d = rx_data;
            state_d = GET_ARG;
          end
          GET_ARG: begin
            arg_r_d = rx_data;
            state_d = GET_CHK;
          end
          default: begin
            state_d = IDLE;
            if (rx_data == (cmd_r_q ^ arg_r_q)) begin
              cmd_valid_d = 1'b1;
              cmd_code_d  = cmd_r_q;
              cmd_arg_d   = arg_r_q;
              if (cmd_r_q == CODE_ON)          out_enable_d = 1'b1;
              else if (cmd_r_q == CODE_OFF)    out_enable_d = 1'b0;
              else if (cmd_r_q == CODE_TOGGLE) out_enable_d = ~out_enable_q;
            end else begin
              frame_error_d = 1'b1;
            end
          end
        endcase
      end
    end else if (timer_q == TMO_LAST) begin
      frame_error_d = 1'b1;
      state_d       = IDLE;
      timer_d       = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end

    if (frame_error_d && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      rx_done_q     <= 1'b1;
      cmd_r_q       <= '0;
      arg_r_q       <= '0;
      cmd_valid_q   <= 1'b0;
      frame_error_q <= 1'b0;
      cmd_code_q    <= '0;
      cmd_arg_q     <= '0;
      err_count_q   <= '0;
      out_enable_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      rx_done_q     <= rx_done;
      cmd_r_q       <= cmd_r_d;
      arg_r_q       <= arg_r_d;
      cmd_valid_q   <= cmd_valid_d;
      frame_error_q <= frame_error_d;
      cmd_code_q    <= cmd_code_d;
      cmd_arg_q     <= cmd_arg_d;
      err_count_q   <= err_count_d;
      out_enable_q  <= out_enable_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign frame_error = frame_error_q;
  assign cmd_code    = cmd_code_q;
  assign cmd_arg     = cmd_arg_q;
  assign err_count   = err_count_q;
  assign out_enable  = out_enable_q;

`ifdef CMD_ECHO_EN
  logic       pending_q, pending_d;
  logic [7:0] pend_byte_q, pend_byte_d;
  logic [7:0] ack_data_q, ack_data_d;
  logic       launch;

  // One-deep ACK/NAK slot; a newer result overwrites an unsent one.
  always_comb begin
    launch      = pending_q & ~tx_busy;
    pending_d   = pending_q & ~launch;
    pend_byte_d = pend_byte_q;
    ack_data_d  = launch ? pend_byte_q : ack_data_q;
    if (cmd_valid_d) begin
      pending_d   = 1'b1;
      pend_byte_d = cmd_r_q;
    end else if (frame_error_d) begin
      pending_d   = 1'b1;
      pend_byte_d = NAK_BYTE;
    end
  end

  // ACK slot registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q   <= 1'b0;
      pend_byte_q <= '0;
      ack_data_q  <= '0;
    end else begin
      pending_q   <= pending_d;
      pend_byte_q <= pend_byte_d;
      ack_data_q  <= ack_data_d;
    end
  end

  // Pulse on the first free cycle; data shown with the pulse and held after.
  assign ack_start = launch;
  assign ack_data  = launch ? pend_byte_q : ack_data_q;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed, table-driven bench for uart_cmd_parser.
module tb_uart_cmd_parser;
  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_parity_error;
  logic       cmd_valid, frame_error, out_enable;
  logic [7:0] cmd_code, cmd_arg, err_count;
`ifdef CMD_ECHO_EN
  logic       tx_busy;
  logic [7:0] ack_data;
  logic       ack_start;
`endif

  int checks = 0;
  int errors = 0;

  uart_cmd_parser #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
    .rx_parity_error(rx_parity_error),
`ifdef CMD_ECHO_EN
    .tx_busy(tx_busy), .ack_data(ack_data), .ack_start(ack_start),
`endif
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_arg(cmd_arg),
    .frame_error(frame_error), .err_count(err_count), .out_enable(out_enable)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       v;
    logic       e;
    logic [7:0] code;
    logic [7:0] arg;
    logic       oe;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Raise rx_done for one cycle; returns at the negedge after the strobe edge,
  // where the registered response to this byte is visible.
  task automatic send_byte(input logic [7:0] d, input logic par);
    @(negedge clk);
    rx_data = d; rx_parity_error = par; rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0; rx_parity_error = 1'b0;
  endtask

  function automatic logic [31:0] outs();
    return {6'd0, cmd_valid, frame_error, cmd_code, cmd_arg, out_enable, err_count[6:0]};
  endfunction

  function automatic logic [31:0] pack(input logic v, e, input logic [7:0] c, a,
                                       input logic oe, input logic [7:0] n);
    return {6'd0, v, e, c, a, oe, n[6:0]};
  endfunction

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    bit seen;
    reset = 1'b1; rx_data = '0; rx_done = 1'b0; rx_parity_error = 1'b0;
`ifdef CMD_ECHO_EN
    tx_busy = 1'b0;
`endif
    //            data  par v  e  code   arg    oe cnt
    vecs[0]  = '{8'h7E, 0, 0, 0, 8'h00, 8'h00, 0, 8'd0};
    vecs[1]  = '{8'hAA, 0, 0, 0, 8'h00, 8'h00, 0, 8'd0};
    vecs[2]  = '{8'h12, 0, 0, 0, 8'h00, 8'h00, 0, 8'd0};
    vecs[3]  = '{8'hB8, 0, 1, 0, 8'hAA, 8'h12, 1, 8'd0};
    vecs[4]  = '{8'h7E, 0, 0, 0, 8'hAA, 8'h12, 1, 8'd0};
    vecs[5]  = '{8'hC3, 0, 0, 0, 8'hAA, 8'h12, 1, 8'd0};
    vecs[6]  = '{8'h00, 0, 0, 0, 8'hAA, 8'h12, 1, 8'd0};
    vecs[7]  = '{8'hC3, 0, 1, 0, 8'hC3, 8'h00, 0, 8'd0};
    vecs[8]  = '{8'h7E, 0, 0, 0, 8'hC3, 8'h00, 0, 8'd0};
    vecs[9]  = '{8'hC3, 0, 0, 0, 8'hC3, 8'h00, 0, 8'd0};
    vecs[10] = '{8'h00, 0, 0, 0, 8'hC3, 8'h00, 0, 8'd0};
    vecs[11] = '{8'hC3, 0, 1, 0, 8'hC3, 8'h00, 1, 8'd0};
    vecs[12] = '{8'h7E, 0, 0, 0, 8'hC3, 8'h00, 1, 8'd0};
    vecs[13] = '{8'h55, 0, 0, 0, 8'hC3, 8'h00, 1, 8'd0};
    vecs[14] = '{8'h01, 0, 0, 0, 8'hC3, 8'h00, 1, 8'd0};
    vecs[15] = '{8'h00, 0, 0, 1, 8'hC3, 8'h00, 1, 8'd1};
    vecs[16] = '{8'h00, 0, 0, 0, 8'hC3, 8'h00, 1, 8'd1};
    vecs[17] = '{8'hFF, 0, 0, 0, 8'hC3, 8'h00, 1, 8'd1};
    vecs[18] = '{8'h7E, 0, 0, 0, 8'hC3, 8'h00, 1, 8'd1};
    vecs[19] = '{8'hAA, 0, 0, 0, 8'hC3, 8'h00, 1, 8'd1};
    vecs[20] = '{8'h12, 1, 0, 1, 8'hC3, 8'h00, 1, 8'd2};
    vecs[21] = '{8'hFF, 1, 0, 0, 8'hC3, 8'h00, 1, 8'd2};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_state", outs(), pack(0, 0, 8'h00, 8'h00, 0, 8'd0));

    // Table: each byte's registered response, then strobes must drop again.
    for (int i = 0; i < 22; i++) begin
      send_byte(vecs[i].data, vecs[i].par);
      chk($sformatf("vec%0d", i), outs(),
          pack(vecs[i].v, vecs[i].e, vecs[i].code, vecs[i].arg, vecs[i].oe, vecs[i].cnt));
      if (vecs[i].v || vecs[i].e) begin
        @(negedge clk);
        chk($sformatf("vec%0d_strobe_1cyc", i), {30'd0, cmd_valid, frame_error}, 32'd0);
      end
    end

    // Timeout: error exactly TMO cycles after the last strobe, not earlier.
    send_byte(8'h7E, 0);
    send_byte(8'hAA, 0);
    seen = 1'b0;
    for (int i = 1; i < TMO; i++) begin
      @(negedge clk);
      if (frame_error) seen = 1'b1;
    end
    chk("timeout_not_early", {31'd0, seen}, 32'd0);
    @(negedge clk);
    chk("timeout_exact", {30'd0, frame_error, cmd_valid}, 32'd2);
    chk("timeout_count", {24'd0, err_count}, 32'd3);
    // Back in IDLE: a clean OFF frame is accepted.
    send_byte(8'h7E, 0); send_byte(8'h55, 0); send_byte(8'h00, 0); send_byte(8'h55, 0);
    chk("after_timeout_off", outs(), pack(1, 0, 8'h55, 8'h00, 0, 8'd3));

    // Byte strobe on the timeout cycle wins over the timeout.
    send_byte(8'h7E, 0);
    repeat (TMO - 2) @(negedge clk);
    send_byte(8'hAA, 0);
    chk("strb_beats_timeout", {30'd0, frame_error, cmd_valid}, 32'd0);
    send_byte(8'h12, 0); send_byte(8'hB8, 0);
    chk("strb_beats_timeout_frame", outs(), pack(1, 0, 8'hAA, 8'h12, 1, 8'd3));

`ifdef CMD_ECHO_EN
    // ACK held off while tx_busy, then a single pulse carrying the code.
    tx_busy = 1'b1;
    send_byte(8'h7E, 0); send_byte(8'hAA, 0); send_byte(8'h00, 0); send_byte(8'hAA, 0);
    seen = 1'b0;
    repeat (4) begin @(negedge clk); if (ack_start) seen = 1'b1; end
    chk("ack_held_off", {31'd0, seen}, 32'd0);
    tx_busy = 1'b0;
    #1;
    chk("ack_pulse", {23'd0, ack_start, ack_data}, {23'd0, 1'b1, 8'hAA});
    @(negedge clk);
    chk("ack_once", {23'd0, ack_start, ack_data}, {23'd0, 1'b0, 8'hAA});
`endif

    // Reset mid-frame: no error strobe, every output back to reset value.
    send_byte(8'h7E, 0); send_byte(8'hC3, 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("midframe_reset", outs(), pack(0, 0, 8'h00, 8'h00, 0, 8'd0));

    // rx_done high across reset release must not yield a byte.
    rx_done = 1'b1; rx_data = 8'h7E;
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    rx_done = 1'b0;
    seen = 1'b0;
    send_byte(8'hAA, 0); if (cmd_valid || frame_error) seen = 1'b1;
    send_byte(8'h00, 0); if (cmd_valid || frame_error) seen = 1'b1;
    send_byte(8'hAA, 0); if (cmd_valid || frame_error) seen = 1'b1;
    chk("level_rx_done_at_reset", {30'd0, seen, out_enable}, 32'd0);

    // Saturating error counter: 260 bad CHK frames.
    for (int i = 0; i < 260; i++) begin
      send_byte(8'h7E, 0); send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
    end
    chk("err_count_saturates", {24'd0, err_count}, 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Framed command parser sitting directly downstream of uart_rx on the main FPGA.
- Consumes the received byte stream and assembles 4-byte frames: SOF, CMD, ARG, CHK.
- Validates each frame and emits one-cycle command strobes.
- Maintains the output-enable state, driven by turn_on / turn_off / toggle, that gates the SPWM / sync logic and the status LED.

Parameters:
- SOF_BYTE, 8'h7E, start-of-frame marker.
- TIMEOUT_CYCLES, 6000, inter-byte timeout in clk cycles (1 ms at 6 MHz); must be ≥ 2.
- CODE_ON, 8'hAA, command code that sets out_enable.
- CODE_OFF, 8'h55, command code that clears out_enable.
- CODE_TOGGLE, 8'hC3, command code that inverts out_enable.

Ports:
- clk  in  1  system clock, 6 MHz from SB_HFOSC.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from uart_rx (data_received).
- rx_done  in  1  byte-complete flag from uart_rx; pulse or level.
- rx_parity_error  in  1  parity flag from uart_rx; qualifies the current byte.
- cmd_valid  out  1  one-cycle strobe: a valid frame was accepted.
- cmd_code  out  8  CMD byte of the last valid frame.
- cmd_arg  out  8  ARG byte of the last valid frame.
- frame_error  out  1  one-cycle strobe: frame aborted.
- err_count  out  8  saturating count of frame errors.
- out_enable  out  1  registered enable state.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high, named reset. All state is updated on posedge clk only.
- Reset values: state=IDLE; cmd_valid=0; frame_error=0; cmd_code=0; cmd_arg=0; err_count=0; out_enable=0; timer=0; rx_done_q=1.
  - rx_done_q resets to 1 so that a level-high rx_done at reset release does not produce a spurious byte.
- Byte strobe: strb = rx_done & ~rx_done_q. rx_done_q is registered every cycle. A byte is bad when strb is high and rx_parity_error=1.
- FSM states: IDLE, GET_CMD, GET_ARG, GET_CHK.
  - IDLE: on strb with a good byte == SOF_BYTE → GET_CMD. Any other byte, good or bad, is silently ignored: no error, no count.
  - GET_CMD: on strb, a good byte is latched into cmd_r → GET_ARG.
  - GET_ARG: on strb, a good byte is latched into arg_r → GET_CHK.
  - GET_CHK: on strb, a good byte equal to (cmd_r ^ arg_r) is a valid frame; otherwise it is a frame error. Next state is IDLE in both cases.
  - Any bad byte in GET_CMD, GET_ARG or GET_CHK → frame error, IDLE.
  - A SOF_BYTE value received after the SOF is treated as ordinary data; there is no resync.
- Timeout:
  - timer clears on every strb and on entry to IDLE.
  - In non-IDLE states timer increments each cycle without strb.
  - When timer == TIMEOUT_CYCLES-1 → frame error, IDLE.
  - If strb and timeout coincide, strb wins: the byte is processed and timer is cleared.
- Output latency: with strb detected at cycle N, cmd_valid or frame_error is high during cycle N+1 only.
  - cmd_code and cmd_arg update in that same cycle and hold until the next valid frame.
- out_enable: updates in the same cycle as cmd_valid.
  - CODE_ON → 1.
  - CODE_OFF → 0.
  - CODE_TOGGLE → ~out_enable.
  - Any other code still raises cmd_valid but leaves out_enable unchanged.
- err_count: +1 on each frame_error; holds at 255 (no wrap).
- cmd_valid and frame_error are never high in the same cycle.
- Reset asserted mid-frame: abandons the frame with no frame_error and returns every output to its reset value the next cycle.

Optional Feature:
Macro CMD_ECHO_EN.
- When defined, adds ports tx_busy (in, 1), ack_data (out, 8) and ack_start (out, 1) for driving uart_tx.
  - Each valid frame queues ack byte = cmd_code; each frame_error queues 8'h15 (NAK).
  - The queue is a one-deep pending register; a newer ack overwrites an unsent one.
  - ack_start is a one-cycle pulse, issued on the first cycle with pending=1 and tx_busy=0. ack_data is stable from that cycle until the next pulse.
  - Reset values: pending=0, ack_start=0, ack_data=0.
- When undefined, these ports and the associated logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then frame 7E AA 12 B8 → cmd_valid one cycle after the 4th strb; cmd_code=AA; cmd_arg=12; out_enable=1; err_count=0.
- Frame 7E C3 00 C3 sent twice → out_enable toggles 1→0→1 across the two cmd_valid pulses; no frame_error.
- Frame 7E 55 01 00 (bad CHK) → frame_error one cycle after the 4th strb; out_enable unchanged; err_count=1.
- 7E AA, then TIMEOUT_CYCLES idle cycles → frame_error after exactly TIMEOUT_CYCLES cycles without strb; state IDLE; a following good 7E 55 00 55 → out_enable=0.
- Parity error on the ARG byte; also bytes 00 FF before SOF → parity case gives frame_error and err_count+1; the pre-SOF bytes are ignored (no error); rx_done held high across reset release → no byte accepted.
- With CMD_ECHO_EN and tx_busy=1 during a valid AA frame → ack_start held off; it pulses once with ack_data=AA on the first cycle tx_busy=0.
